// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 16-bit signed ALU with single-cycle ADD/SUB and an iterative
// shift-add multiplier plus an optional restoring divider.
//
// Ports
//   clk    in   1   clock, all state changes on the rising edge
//   rst    in   1   synchronous active-high reset
//   A, B   in  16   signed two's-complement operands
//   ALUOP  in   2   00 ADD, 01 SUB, 10 MUL, 11 DIV
//   Result out 16   registered result
//   carry  out  1   registered flag: ADD carry-out, SUB borrow,
//                   MUL signed overflow, DIV divide-by-zero
//   zero   out  1   Result == 0
//   busy   out  1   MUL/DIV iteration in progress
//
// Configuration macro: ALU_DIV_EN compiles in the divider. Without it,
// ALUOP 11 returns Result 0 / carry 1 after one cycle and never sets busy.
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [1:0]  ALUOP,
    output logic [15:0] Result,
    output logic        carry,
    output logic        zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t      stateQ;
    logic [1:0]  opQ;
    logic [15:0] aQ;
    logic [15:0] bQ;
    logic [15:0] resultQ;
    logic        carryQ;
    logic [3:0]  cntQ;
    logic        negQ;
    logic [31:0] accQ;
    logic [31:0] mcandQ;
    logic [15:0] mplierQ;

    logic [16:0] addSum;
    logic [15:0] subDiff;
    logic [15:0] aMag;
    logic [15:0] bMag;
    logic        changed;
    logic [31:0] accD;
    logic [31:0] mulProd;
    logic        mulOvf;

`ifdef ALU_DIV_EN
    logic [15:0] remQ;
    logic [15:0] quoQ;
    logic [15:0] divisorQ;
    logic        divZeroQ;

    logic [16:0] divShift;
    logic        divGe;
    logic [15:0] remD;
    logic [15:0] quoD;
    logic [15:0] divQuo;
`endif

    // Datapath for the single-cycle ops and one step of each iterative unit.
    // Both MUL and DIV work on operand magnitudes; the sign is applied once
    // on the final step. |-32768| = 0x8000 still fits as an unsigned magnitude.
    always_comb begin
        addSum  = {1'b0, A} + {1'b0, B};
        subDiff = A - B;
        aMag    = A[15] ? (~A + 16'd1) : A;
        bMag    = B[15] ? (~B + 16'd1) : B;
        changed = ({ALUOP, A, B} != {opQ, aQ, bQ});

        accD    = mplierQ[0] ? (accQ + mcandQ) : accQ;
        mulProd = negQ ? (~accD + 32'd1) : accD;
        // Overflow when the 32-bit product is not a sign extension of bit 15.
        mulOvf  = (mulProd[31:15] != {17{mulProd[15]}});

`ifdef ALU_DIV_EN
        // Restoring step: the partial remainder is always below the divisor,
        // so the 16-bit subtraction below is exact whenever divGe is set.
        divShift = {remQ, quoQ[15]};
        divGe    = (divShift >= {1'b0, divisorQ});
        remD     = divGe ? (divShift[15:0] - divisorQ) : divShift[15:0];
        quoD     = {quoQ[14:0], divGe};
        divQuo   = negQ ? (~quoD + 16'd1) : quoD;
`endif
    end

    // Control and all registered state. ADD/SUB overwrite opQ so that a later
    // MUL/DIV on the same operands is seen as new work. A MUL/DIV whose
    // {ALUOP, A, B} differs from the captured copy restarts the iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= S_IDLE;
            opQ      <= 2'b00;
            aQ       <= 16'd0;
            bQ       <= 16'd0;
            resultQ  <= 16'd0;
            carryQ   <= 1'b0;
            cntQ     <= 4'd0;
            negQ     <= 1'b0;
            accQ     <= 32'd0;
            mcandQ   <= 32'd0;
            mplierQ  <= 16'd0;
`ifdef ALU_DIV_EN
            remQ     <= 16'd0;
            quoQ     <= 16'd0;
            divisorQ <= 16'd0;
            divZeroQ <= 1'b0;
`endif
        end else begin
            case (ALUOP)
                2'b00: begin
                    resultQ <= addSum[15:0];
                    carryQ  <= addSum[16];
                    stateQ  <= S_IDLE;
                    opQ     <= ALUOP;
                    cntQ    <= 4'd0;
                end
                2'b01: begin
                    resultQ <= subDiff;
                    carryQ  <= (A < B);
                    stateQ  <= S_IDLE;
                    opQ     <= ALUOP;
                    cntQ    <= 4'd0;
                end
                2'b10: begin
                    if (changed) begin
                        opQ     <= ALUOP;
                        aQ      <= A;
                        bQ      <= B;
                        stateQ  <= S_MUL;
                        cntQ    <= 4'd0;
                        negQ    <= A[15] ^ B[15];
                        accQ    <= 32'd0;
                        mcandQ  <= {16'd0, aMag};
                        mplierQ <= bMag;
                    end else if (stateQ == S_MUL) begin
                        accQ    <= accD;
                        mcandQ  <= mcandQ << 1;
                        mplierQ <= mplierQ >> 1;
                        cntQ    <= cntQ + 4'd1;
                        if (cntQ == 4'd15) begin
                            resultQ <= mulProd[15:0];
                            carryQ  <= mulOvf;
                            stateQ  <= S_IDLE;
                            cntQ    <= 4'd0;
                        end
                    end
                end
                2'b11: begin
`ifdef ALU_DIV_EN
                    if (changed) begin
                        opQ      <= ALUOP;
                        aQ       <= A;
                        bQ       <= B;
                        stateQ   <= S_DIV;
                        cntQ     <= 4'd0;
                        negQ     <= A[15] ^ B[15];
                        remQ     <= 16'd0;
                        quoQ     <= aMag;
                        divisorQ <= bMag;
                        divZeroQ <= (B == 16'd0);
                    end else if (stateQ == S_DIV) begin
                        remQ <= remD;
                        quoQ <= quoD;
                        cntQ <= cntQ + 4'd1;
                        if (cntQ == 4'd15) begin
                            resultQ <= divZeroQ ? 16'hFFFF : divQuo;
                            carryQ  <= divZeroQ;
                            stateQ  <= S_IDLE;
                            cntQ    <= 4'd0;
                        end
                    end
`else
                    resultQ <= 16'd0;
                    carryQ  <= 1'b1;
                    stateQ  <= S_IDLE;
                    opQ     <= ALUOP;
                    cntQ    <= 4'd0;
`endif
                end
            endcase
        end
    end

    assign Result = resultQ;
    assign carry  = carryQ;
    assign zero   = (resultQ == 16'd0);
    assign busy   = (stateQ != S_IDLE);

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Expected {Result, carry} pairs are
// pushed to a scoreboard queue when a vector is driven and popped when the
// DUT output is due. DIV expectations follow ALU_DIV_EN.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  ALUOP;
    logic [15:0] Result;
    logic        carry;
    logic        zero;
    logic        busy;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic        c;
    } exp_t;

    exp_t sbQ[$];
    int   vecCount = 0;
    int   errCount = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .ALUOP  (ALUOP),
        .Result (Result),
        .carry  (carry),
        .zero   (zero),
        .busy   (busy)
    );

    // Reference arithmetic in 32-bit integers.
    function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] op);
        exp_t        e;
        int          sa;
        int          sb;
        int          p;
        logic [16:0] s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'b00: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[15:0];
                e.c   = s[16];
            end
            2'b01: begin
                e.res = a - b;
                e.c   = (a < b);
            end
            2'b10: begin
                p     = sa * sb;
                e.res = p[15:0];
                e.c   = (p > 32767) || (p < -32768);
            end
            default: begin
                if (!DIV_EN) begin
                    e.res = 16'd0;
                    e.c   = 1'b1;
                end else if (b == 16'd0) begin
                    e.res = 16'hFFFF;
                    e.c   = 1'b1;
                end else begin
                    p     = sa / sb;
                    e.res = p[15:0];
                    e.c   = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    function automatic bit isMulti(input logic [1:0] op);
        return (op == 2'b10) || (DIV_EN && (op == 2'b11));
    endfunction

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op);
        @(negedge clk);
        A     = a;
        B     = b;
        ALUOP = op;
        sbQ.push_back(refModel(a, b, op));
    endtask

    // Waits for the result of the vector just driven, bounded to 18 cycles.
    task automatic awaitOutput(input logic [1:0] op, output bit done, output bit sawBusy);
        done    = 1'b0;
        sawBusy = 1'b0;
        if (!isMulti(op)) begin
            @(posedge clk);
            @(negedge clk);
            done = 1'b1;
        end else begin
            for (int k = 1; k <= 18; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k == 1) sawBusy = busy;
                if (k > 1 && !busy) begin
                    done = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        A     = 16'd0;
        B     = 16'd0;
        ALUOP = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecCount++;
        if ({Result, carry, busy, zero} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
            errCount++;
            $display("[TB] FAIL reset: Result/carry/busy/zero got %h/%b/%b/%b expected 0000/0/0/1",
                     Result, carry, busy, zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        logic [15:0] ta[6] = '{16'd100, 16'h8000, 16'd5, 16'hFFFF, 16'd3, 16'h7FFF};
        logic [15:0] tb[6] = '{16'hFF06, 16'd1, 16'd5, 16'd1, 16'd5, 16'd1};
        logic [1:0]  to[6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        exp_t e;
        bit   done;
        bit   sb;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ta[i], tb[i], to[i]);
            awaitOutput(to[i], done, sb);
            e = sbQ.pop_front();
            vecCount++;
            if ({Result, carry} !== {e.res, e.c}) begin
                errCount++;
                $display("[TB] FAIL addsub[%0d]: got %h/%b expected %h/%b", i, Result, carry, e.res, e.c);
            end
            vecCount++;
            if (zero !== (e.res == 16'd0)) begin
                errCount++;
                $display("[TB] FAIL addsub_zero[%0d]: got %b expected %b", i, zero, e.res == 16'd0);
            end
        end
    endtask

    task automatic test_mul_div();
        logic [15:0] ta[8] = '{16'hFED4, 16'hFFF9, 16'd1000, 16'h8000, 16'h8000, 16'd123, 16'd7, 16'd0};
        logic [15:0] tb[8] = '{16'd200, 16'd2, 16'd0, 16'hFFFF, 16'h8000, 16'hFFD3, 16'hFFFE, 16'd9};
        logic [1:0]  to[8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        exp_t e;
        bit   done;
        bit   sb;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ta[i], tb[i], to[i]);
            awaitOutput(to[i], done, sb);
            e = sbQ.pop_front();
            vecCount++;
            if (!done || {Result, carry} !== {e.res, e.c}) begin
                errCount++;
                $display("[TB] FAIL muldiv[%0d]: done=%b got %h/%b expected %h/%b",
                         i, done, Result, carry, e.res, e.c);
            end
            if (isMulti(to[i])) begin
                vecCount++;
                if (sb !== 1'b1) begin
                    errCount++;
                    $display("[TB] FAIL muldiv_busy[%0d]: busy after start got %b expected 1", i, sb);
                end
            end
        end
    endtask

    task automatic test_hold_abort();
        exp_t e;
        exp_t dummy;
        bit   done;
        bit   sb;
        // Completed MUL holds while inputs stay unchanged.
        applyStimulus(16'd300, 16'hFFF9, 2'b10);
        awaitOutput(2'b10, done, sb);
        e = sbQ.pop_front();
        vecCount++;
        if (!done || {Result, carry} !== {e.res, e.c}) begin
            errCount++;
            $display("[TB] FAIL hold_first: got %h/%b expected %h/%b", Result, carry, e.res, e.c);
        end
        repeat (5) @(negedge clk);
        vecCount++;
        if ({Result, carry, busy} !== {e.res, e.c, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL hold_idle: got %h/%b busy %b expected %h/%b busy 0",
                     Result, carry, busy, e.res, e.c);
        end
        // Result holds while a new MUL is busy, then ADD aborts it.
        applyStimulus(16'd1234, 16'd56, 2'b10);
        repeat (3) @(negedge clk);
        vecCount++;
        if ({Result, busy} !== {e.res, 1'b1}) begin
            errCount++;
            $display("[TB] FAIL busy_hold: got %h busy %b expected %h busy 1", Result, busy, e.res);
        end
        dummy = sbQ.pop_front();
        applyStimulus(16'd1234, 16'd56, 2'b00);
        @(negedge clk);
        e = sbQ.pop_front();
        vecCount++;
        if ({Result, carry, busy} !== {e.res, e.c, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL abort_add: got %h/%b busy %b expected %h/%b busy 0",
                     Result, carry, busy, e.res, e.c);
        end
        // Changing B mid-MUL restarts with the new operands.
        applyStimulus(16'd40, 16'd50, 2'b10);
        repeat (4) @(negedge clk);
        dummy = sbQ.pop_front();
        applyStimulus(16'd40, 16'hFFC4, 2'b10);
        awaitOutput(2'b10, done, sb);
        e = sbQ.pop_front();
        vecCount++;
        if (!done || {Result, carry} !== {e.res, e.c}) begin
            errCount++;
            $display("[TB] FAIL restart: got %h/%b expected %h/%b", Result, carry, e.res, e.c);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   done;
        bit   sb;
        applyStimulus(16'hFED4, 16'd200, 2'b10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecCount++;
        if ({Result, carry, busy} !== {16'd0, 1'b0, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL reset_mid: got %h/%b busy %b expected 0000/0 busy 0", Result, carry, busy);
        end
        rst = 1'b0;
        awaitOutput(2'b10, done, sb);
        e = sbQ.pop_front();
        vecCount++;
        if (!done || sb !== 1'b1 || {Result, carry} !== {e.res, e.c}) begin
            errCount++;
            $display("[TB] FAIL reset_recompute: done=%b busy=%b got %h/%b expected %h/%b",
                     done, sb, Result, carry, e.res, e.c);
        end
    endtask

    task automatic test_sweep();
        exp_t        e;
        bit          done;
        bit          sb;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 637; i += 3) begin
            a = 16'(-32768 + i * 103);
            b = 16'(-32768 + ((i * 211) % 637) * 103);
            for (int op = 0; op < 4; op++) begin
                if (op == 3 && b == 16'd0) continue;
                applyStimulus(a, b, 2'(op));
                awaitOutput(2'(op), done, sb);
                e = sbQ.pop_front();
                vecCount++;
                if (!done || {Result, carry} !== {e.res, e.c}) begin
                    errCount++;
                    $display("[TB] FAIL sweep op%0d a=%h b=%h: got %h/%b expected %h/%b",
                             op, a, b, Result, carry, e.res, e.c);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sbQ.pop_front();
                vecCount++;
                if ({Result, carry} !== {e.res, e.c}) begin
                    errCount++;
                    $display("[TB] FAIL b2b[%0d]: got %h/%b expected %h/%b", i, Result, carry, e.res, e.c);
                end
            end
            if (i < 12) begin
                a     = 16'($urandom);
                b     = 16'($urandom);
                op    = 2'(i % 2);
                A     = a;
                B     = b;
                ALUOP = op;
                sbQ.push_back(refModel(a, b, op));
            end
        end
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_mul_div();
        test_hold_abort();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 A  input  16  signed two's-complement operand A.
REQ-004 B  input  16  signed two's-complement operand B.
REQ-005 ALUOP  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 Result  output  16  signed registered result.
REQ-007 carry  output  1  registered status flag; meaning depends on the operation (REQ-014).
REQ-008 zero  output  1  high when Result equals 0; derived combinationally from the Result register.
REQ-009 busy  output  1  high while a MUL or DIV computation is in progress.

Function
REQ-010 ADD: Result = low 16 bits of A+B, registered at the first rising edge after A, B and ALUOP are applied (1-cycle latency).
REQ-011 SUB: Result = low 16 bits of A-B, with 1-cycle latency.
REQ-012 MUL: Result = low 16 bits of the signed 32-bit product A*B, computed by an iterative shift-add unit; valid at most 18 cycles after the operands are applied.
REQ-013 DIV: Result = signed quotient A/B, truncated toward zero (remainder discarded), computed by an iterative restoring or non-restoring divider on magnitudes with sign fix-up; valid at most 18 cycles after the operands are applied.
REQ-014 carry: ADD = unsigned carry-out of bit 15; SUB = 1 when unsigned A < unsigned B (borrow); MUL = 1 when the signed 32-bit product does not fit in 16 signed bits; DIV = 1 on divide-by-zero, otherwise 0.
REQ-015 Divide-by-zero: Result = 16'hFFFF, carry = 1, with the normal DIV latency.
REQ-016 DIV of -32768 by -1: Result = -32768 (wrapped), carry = 0.
REQ-017 MUL/DIV start: the block keeps copies of {ALUOP, A, B}; whenever ALUOP is 10 or 11 and the inputs differ from the copies, it captures the new inputs, sets busy, and aborts any computation in progress.
REQ-018 While busy, Result and carry hold their last values; on completion they update in the same cycle that busy falls.
REQ-019 After completion, Result holds indefinitely while inputs are unchanged; no recomputation occurs.
REQ-020 Switching ALUOP to 00 or 01 mid-computation aborts the MUL/DIV, clears busy, and applies REQ-010/011 on the next edge.

Reset
REQ-021 While rst is high at a rising edge: Result = 0, carry = 0, busy = 0, captured copies cleared, and the iteration counter cleared (zero therefore = 1).
REQ-022 Reset during a MUL or DIV aborts it; the first edge after rst falls restarts the computation per REQ-017 using the current inputs.

Configuration
REQ-023 Macro ALU_DIV_EN: when defined, the divider is compiled in and DIV behaves per REQ-013, REQ-015 and REQ-016.
REQ-024 Without ALU_DIV_EN: no divider logic exists; ALUOP 11 yields Result = 0 and carry = 1 with 1-cycle latency, and busy stays 0.

Verification (ALU_DIV_EN defined)
REQ-025 A=100, B=-250, ALUOP=00 -> after 1 cycle, Result=-150, zero=0.
REQ-026 A=-32768, B=1, ALUOP=01 -> Result=32767 (wrap), carry=0; A=5, B=5 -> Result=0, zero=1.
REQ-027 A=-300, B=200, ALUOP=10 -> within 18 cycles, Result = low 16 bits of -60000 (5536), carry=1; busy falls in the same cycle.
REQ-028 A=-7, B=2, ALUOP=11 -> Result=-3; A=1000, B=0 -> Result=16'hFFFF, carry=1.
REQ-029 Sweep A and B from -32768 to 32767 in steps of 103, all four operations, holding each vector 20 cycles -> every Result matches the reference arithmetic, with DIV by 0 excluded.
REQ-030 Assert rst at cycle 5 of a MUL -> next cycle Result=0 and busy=0; deassert rst -> the MUL recomputes and completes within 18 cycles.
